pipe_front_regs: RTL and testbench

- Datapath-side consumer of the pipeline hazard controls for the 5-stage RV32I core.
- Holds the fetch PC, the IF/ID register and the ID/EX register, and applies stall, flush and redirect.
- Exports the register indices that the hazard unit compares.
- Performs the execute-stage operand forwarding mux selected by forward_a_e/forward_b_e.

---
 rtl/pipe_front_regs.sv | 193 +++++++++++++++++++
 tb/tb_pipe_front_regs.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_front_regs.sv
//------------------------------------------------------------------------------
// Module  : pipe_front_regs
// Brief   : Fetch PC, IF/ID and ID/EX pipeline registers with stall, flush and
//           redirect, plus execute-stage operand forwarding muxes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_f_i,
  input  logic              pc_src_e_i,
  input  logic [31:0]       pc_target_e_i,
  input  logic              stall_f_i,
  input  logic              stall_d_i,
  input  logic              flush_d_i,
  input  logic              flush_e_i,
  input  logic [1:0]        forward_a_e_i,
  input  logic [1:0]        forward_b_e_i,
  input  logic [31:0]       rd1_d_i,
  input  logic [31:0]       rd2_d_i,
  input  logic [31:0]       imm_ext_d_i,
  input  logic [CTRL_W-1:0] ctrl_d_i,
  input  logic [31:0]       alu_result_m_i,
  input  logic [31:0]       result_w_i,
  output logic [31:0]       pc_f_o,
  output logic [31:0]       instr_d_o,
  output logic [31:0]       pc_d_o,
  output logic [31:0]       pc_plus4_d_o,
  output logic [4:0]        rs1_d_o,
  output logic [4:0]        rs2_d_o,
  output logic [4:0]        rs1_e_o,
  output logic [4:0]        rs2_e_o,
  output logic [4:0]        rd_e_o,
  output logic [31:0]       pc_e_o,
  output logic [31:0]       pc_plus4_e_o,
  output logic [31:0]       imm_ext_e_o,
  output logic [CTRL_W-1:0] ctrl_e_o,
  output logic [31:0]       src_a_e_o,
  output logic [31:0]       write_data_e_o,
  output logic              valid_d_o,
  output logic              valid_e_o
);

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  logic [31:0]       pc_q,       pc_d;
  logic [31:0]       instr_dq_q, instr_dq_d;
  logic [31:0]       pc_dq_q,    pc_dq_d;
  logic [31:0]       pc4_dq_q,   pc4_dq_d;
  logic              vld_dq_q,   vld_dq_d;
  logic [4:0]        rs1_eq_q,   rs1_eq_d;
  logic [4:0]        rs2_eq_q,   rs2_eq_d;
  logic [4:0]        rd_eq_q,    rd_eq_d;
  logic [31:0]       rd1_eq_q,   rd1_eq_d;
  logic [31:0]       rd2_eq_q,   rd2_eq_d;
  logic [31:0]       imm_eq_q,   imm_eq_d;
  logic [CTRL_W-1:0] ctrl_eq_q,  ctrl_eq_d;
  logic [31:0]       pc_eq_q,    pc_eq_d;
  logic [31:0]       pc4_eq_q,   pc4_eq_d;
  logic              vld_eq_q,   vld_eq_d;

  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = pc_q + 32'd4;

  always_comb begin
    // Redirect outranks stall so a resolved branch is never dropped.
    pc_d = w_pc_plus4;
    if (pc_src_e_i) begin
      pc_d = pc_target_e_i;
    end else if (stall_f_i) begin
      pc_d = pc_q;
    end

    instr_dq_d = instr_f_i;
    pc_dq_d    = pc_q;
    pc4_dq_d   = w_pc_plus4;
    vld_dq_d   = 1'b1;
    if (flush_d_i) begin
      instr_dq_d = NOP_INSTR;
      pc_dq_d    = 32'd0;
      pc4_dq_d   = 32'd0;
      vld_dq_d   = 1'b0;
    end else if (stall_d_i) begin
      instr_dq_d = instr_dq_q;
      pc_dq_d    = pc_dq_q;
      pc4_dq_d   = pc4_dq_q;
      vld_dq_d   = vld_dq_q;
    end

    rs1_eq_d  = instr_dq_q[19:15];
    rs2_eq_d  = instr_dq_q[24:20];
    rd_eq_d   = instr_dq_q[11:7];
    rd1_eq_d  = rd1_d_i;
    rd2_eq_d  = rd2_d_i;
    imm_eq_d  = imm_ext_d_i;
    ctrl_eq_d = ctrl_d_i;
    pc_eq_d   = pc_dq_q;
    pc4_eq_d  = pc4_dq_q;
    vld_eq_d  = vld_dq_q;
    // A bubble zeroes rd so no forwarding or load-use compare can hit it.
    if (flush_e_i) begin
      rs1_eq_d  = 5'd0;
      rs2_eq_d  = 5'd0;
      rd_eq_d   = 5'd0;
      rd1_eq_d  = 32'd0;
      rd2_eq_d  = 32'd0;
      imm_eq_d  = 32'd0;
      ctrl_eq_d = '0;
      pc_eq_d   = 32'd0;
      pc4_eq_d  = 32'd0;
      vld_eq_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      instr_dq_q <= NOP_INSTR;
      pc_dq_q    <= 32'd0;
      pc4_dq_q   <= 32'd0;
      vld_dq_q   <= 1'b0;
      rs1_eq_q   <= 5'd0;
      rs2_eq_q   <= 5'd0;
      rd_eq_q    <= 5'd0;
      rd1_eq_q   <= 32'd0;
      rd2_eq_q   <= 32'd0;
      imm_eq_q   <= 32'd0;
      ctrl_eq_q  <= '0;
      pc_eq_q    <= 32'd0;
      pc4_eq_q   <= 32'd0;
      vld_eq_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_dq_q <= instr_dq_d;
      pc_dq_q    <= pc_dq_d;
      pc4_dq_q   <= pc4_dq_d;
      vld_dq_q   <= vld_dq_d;
      rs1_eq_q   <= rs1_eq_d;
      rs2_eq_q   <= rs2_eq_d;
      rd_eq_q    <= rd_eq_d;
      rd1_eq_q   <= rd1_eq_d;
      rd2_eq_q   <= rd2_eq_d;
      imm_eq_q   <= imm_eq_d;
      ctrl_eq_q  <= ctrl_eq_d;
      pc_eq_q    <= pc_eq_d;
      pc4_eq_q   <= pc4_eq_d;
      vld_eq_q   <= vld_eq_d;
    end
  end

  always_comb begin
    case (forward_a_e_i)
      FWD_W:   src_a_e_o = result_w_i;
      FWD_M:   src_a_e_o = alu_result_m_i;
      FWD_RF:  src_a_e_o = rd1_eq_q;
      default: src_a_e_o = rd1_eq_q;
    endcase
    case (forward_b_e_i)
      FWD_W:   write_data_e_o = result_w_i;
      FWD_M:   write_data_e_o = alu_result_m_i;
      FWD_RF:  write_data_e_o = rd2_eq_q;
      default: write_data_e_o = rd2_eq_q;
    endcase
  end

  assign pc_f_o       = pc_q;
  assign instr_d_o    = instr_dq_q;
  assign pc_d_o       = pc_dq_q;
  assign pc_plus4_d_o = pc4_dq_q;
  assign valid_d_o    = vld_dq_q;
  assign rs1_d_o      = instr_dq_q[19:15];
  assign rs2_d_o      = instr_dq_q[24:20];
  assign rs1_e_o      = rs1_eq_q;
  assign rs2_e_o      = rs2_eq_q;
  assign rd_e_o       = rd_eq_q;
  assign pc_e_o       = pc_eq_q;
  assign pc_plus4_e_o = pc4_eq_q;
  assign imm_ext_e_o  = imm_eq_q;
  assign ctrl_e_o     = ctrl_eq_q;
  assign valid_e_o    = vld_eq_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_front_regs.sv
//------------------------------------------------------------------------------
// Module  : tb_pipe_front_regs
// Brief   : Directed plus random stimulus for pipe_front_regs against a
//           stage-packet reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_front_regs;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          CTRL_W    = 16;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [31:0]       instr_f_i;
  logic              pc_src_e_i;
  logic [31:0]       pc_target_e_i;
  logic              stall_f_i, stall_d_i, flush_d_i, flush_e_i;
  logic [1:0]        forward_a_e_i, forward_b_e_i;
  logic [31:0]       rd1_d_i, rd2_d_i, imm_ext_d_i;
  logic [CTRL_W-1:0] ctrl_d_i;
  logic [31:0]       alu_result_m_i, result_w_i;
  logic [31:0]       pc_f_o, instr_d_o, pc_d_o, pc_plus4_d_o;
  logic [4:0]        rs1_d_o, rs2_d_o, rs1_e_o, rs2_e_o, rd_e_o;
  logic [31:0]       pc_e_o, pc_plus4_e_o, imm_ext_e_o;
  logic [CTRL_W-1:0] ctrl_e_o;
  logic [31:0]       src_a_e_o, write_data_e_o;
  logic              valid_d_o, valid_e_o;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_front_regs #(
    .RESET_PC(RESET_PC), .CTRL_W(CTRL_W), .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_f_i(instr_f_i),
    .pc_src_e_i(pc_src_e_i), .pc_target_e_i(pc_target_e_i),
    .stall_f_i(stall_f_i), .stall_d_i(stall_d_i),
    .flush_d_i(flush_d_i), .flush_e_i(flush_e_i),
    .forward_a_e_i(forward_a_e_i), .forward_b_e_i(forward_b_e_i),
    .rd1_d_i(rd1_d_i), .rd2_d_i(rd2_d_i), .imm_ext_d_i(imm_ext_d_i),
    .ctrl_d_i(ctrl_d_i), .alu_result_m_i(alu_result_m_i),
    .result_w_i(result_w_i), .pc_f_o(pc_f_o), .instr_d_o(instr_d_o),
    .pc_d_o(pc_d_o), .pc_plus4_d_o(pc_plus4_d_o),
    .rs1_d_o(rs1_d_o), .rs2_d_o(rs2_d_o), .rs1_e_o(rs1_e_o),
    .rs2_e_o(rs2_e_o), .rd_e_o(rd_e_o), .pc_e_o(pc_e_o),
    .pc_plus4_e_o(pc_plus4_e_o), .imm_ext_e_o(imm_ext_e_o),
    .ctrl_e_o(ctrl_e_o), .src_a_e_o(src_a_e_o),
    .write_data_e_o(write_data_e_o), .valid_d_o(valid_d_o),
    .valid_e_o(valid_e_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: each stage holds an instruction packet; register
  // indices are simply fields of the instruction word carried in E.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } d_pkt_t;

  typedef struct {
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [31:0]       rd1;
    logic [31:0]       rd2;
    logic [31:0]       imm;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } e_pkt_t;

  logic [31:0] m_pc;
  d_pkt_t      m_d;
  e_pkt_t      m_e;

  function automatic d_pkt_t d_bubble();
    d_pkt_t p;
    p.instr = NOP_INSTR; p.pc = 32'd0; p.valid = 1'b0;
    return p;
  endfunction

  function automatic e_pkt_t e_bubble();
    e_pkt_t p;
    p.instr = 32'd0; p.pc = 32'd0; p.rd1 = 32'd0; p.rd2 = 32'd0;
    p.imm = 32'd0; p.ctrl = '0; p.valid = 1'b0;
    return p;
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                      input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return rf;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ex_pc4;
    ex_pc4 = m_e.valid ? m_e.pc + 32'd4 : 32'd0;
    chk({tag, " pc_f"},    pc_f_o, m_pc);
    chk({tag, " instr_d"}, instr_d_o, m_d.instr);
    chk({tag, " pc_d"},    pc_d_o, m_d.pc);
    chk({tag, " pc4_d"},   pc_plus4_d_o, m_d.valid ? m_d.pc + 32'd4 : 32'd0);
    chk({tag, " valid_d"}, 32'(valid_d_o), 32'(m_d.valid));
    chk({tag, " rs1_d"},   32'(rs1_d_o), (m_d.instr >> 15) & 32'h1F);
    chk({tag, " rs2_d"},   32'(rs2_d_o), (m_d.instr >> 20) & 32'h1F);
    chk({tag, " rs1_e"},   32'(rs1_e_o), (m_e.instr >> 15) & 32'h1F);
    chk({tag, " rs2_e"},   32'(rs2_e_o), (m_e.instr >> 20) & 32'h1F);
    chk({tag, " rd_e"},    32'(rd_e_o), (m_e.instr >> 7) & 32'h1F);
    chk({tag, " pc_e"},    pc_e_o, m_e.pc);
    chk({tag, " pc4_e"},   pc_plus4_e_o, ex_pc4);
    chk({tag, " imm_e"},   imm_ext_e_o, m_e.imm);
    chk({tag, " ctrl_e"},  32'(ctrl_e_o), 32'(m_e.ctrl));
    chk({tag, " valid_e"}, 32'(valid_e_o), 32'(m_e.valid));
    chk({tag, " src_a"},   src_a_e_o,
        fwd(forward_a_e_i, m_e.rd1, result_w_i, alu_result_m_i));
    chk({tag, " wdata"},   write_data_e_o,
        fwd(forward_b_e_i, m_e.rd2, result_w_i, alu_result_m_i));
  endtask

  // Advance model with current inputs, clock the DUT, then compare.
  task automatic step(input string tag);
    d_pkt_t nd;
    e_pkt_t ne;
    logic [31:0] npc;
    if (rst_i) begin
      npc = RESET_PC; nd = d_bubble(); ne = e_bubble();
    end else begin
      npc = pc_src_e_i ? pc_target_e_i : (stall_f_i ? m_pc : m_pc + 32'd4);
      if (flush_d_i)      nd = d_bubble();
      else if (stall_d_i) nd = m_d;
      else begin
        nd.instr = instr_f_i; nd.pc = m_pc; nd.valid = 1'b1;
      end
      if (flush_e_i) ne = e_bubble();
      else begin
        // A D-stage bubble still carries the NOP word and zero PC forward.
        ne.instr = m_d.instr; ne.pc = m_d.pc; ne.valid = m_d.valid;
        ne.rd1 = rd1_d_i; ne.rd2 = rd2_d_i; ne.imm = imm_ext_d_i;
        ne.ctrl = ctrl_d_i;
      end
    end
    @(posedge clk_i);
    #1;
    m_pc = npc; m_d = nd; m_e = ne;
    if (!m_e.valid && m_e.pc == 32'd0) m_e.pc = 32'd0;
    check_all(tag);
  endtask

  task automatic quiet();
    rst_i = 1'b0; pc_src_e_i = 1'b0; stall_f_i = 1'b0; stall_d_i = 1'b0;
    flush_d_i = 1'b0; flush_e_i = 1'b0;
  endtask

  initial begin
    m_pc = 32'd0; m_d = d_bubble(); m_e = e_bubble();
    quiet();
    instr_f_i = 32'h0050_0093; pc_target_e_i = 32'h0;
    forward_a_e_i = 2'd0; forward_b_e_i = 2'd0;
    rd1_d_i = 32'd0; rd2_d_i = 32'd0; imm_ext_d_i = 32'h5; ctrl_d_i = 16'hA5A5;
    alu_result_m_i = 32'h22; result_w_i = 32'h33;

    // Reset overriding active stall/flush/redirect.
    rst_i = 1'b1; stall_f_i = 1'b1; flush_d_i = 1'b1; pc_src_e_i = 1'b1;
    pc_target_e_i = 32'h40;
    step("reset");
    step("reset2");
    chk("reset pc", pc_f_o, RESET_PC);
    quiet();

    for (int i = 0; i < 4; i++) step("run");
    chk("run pc16", pc_f_o, 32'd16);
    chk("run instr_d", instr_d_o, 32'h0050_0093);

    // Load-use on add x2,x1,x2 sitting in D.
    instr_f_i = 32'h0020_8133;
    step("lu_load");
    instr_f_i = 32'h0000_0000;
    stall_f_i = 1'b1; stall_d_i = 1'b1; flush_e_i = 1'b1;
    step("lu_stall");
    chk("lu instr_d held", instr_d_o, 32'h0020_8133);
    chk("lu bubble rd_e", 32'(rd_e_o), 32'd0);
    quiet();
    step("lu_release");
    chk("lu rd_e", 32'(rd_e_o), 32'd2);
    chk("lu rs1_e", 32'(rs1_e_o), 32'd1);

    // Branch redirect with flushes and a concurrent fetch stall.
    pc_src_e_i = 1'b1; pc_target_e_i = 32'h100;
    flush_d_i = 1'b1; flush_e_i = 1'b1; stall_f_i = 1'b1;
    step("branch");
    chk("branch pc", pc_f_o, 32'h100);
    quiet();
    step("branch_resume");
    chk("branch resume pc", pc_f_o, 32'h104);

    // Forwarding sweep on registered rd1=0x11, rd2=0x44.
    rd1_d_i = 32'h11; rd2_d_i = 32'h44;
    step("fwd_load");
    for (int s = 0; s < 4; s++) begin
      forward_a_e_i = 2'(s); forward_b_e_i = 2'(3 - s);
      #1;
      chk("fwd src_a", src_a_e_o, (s == 1) ? 32'h33 : (s == 2) ? 32'h22 : 32'h11);
      chk("fwd wdata", write_data_e_o, (s == 2) ? 32'h33 : (s == 1) ? 32'h22 : 32'h44);
    end
    forward_a_e_i = 2'd0; forward_b_e_i = 2'd0;

    // Flush beats stall in IF/ID.
    flush_d_i = 1'b1; stall_d_i = 1'b1;
    step("flush_stall");
    chk("fs instr_d", instr_d_o, NOP_INSTR);
    quiet();

    // PC wrap-around.
    pc_src_e_i = 1'b1; pc_target_e_i = 32'hFFFF_FFFC;
    step("wrap_set");
    quiet();
    step("wrap");
    chk("wrap pc", pc_f_o, 32'd0);

    // Reset asserted while stalled.
    stall_f_i = 1'b1; stall_d_i = 1'b1;
    step("pre_rst");
    rst_i = 1'b1;
    step("rst_stall");
    chk("rst_stall valid_d", 32'(valid_d_o), 32'd0);
    quiet();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst_i          = ($urandom_range(0, 39) == 0);
      pc_src_e_i     = ($urandom_range(0, 7) == 0);
      pc_target_e_i  = $urandom;
      stall_f_i      = ($urandom_range(0, 4) == 0);
      stall_d_i      = ($urandom_range(0, 4) == 0);
      flush_d_i      = ($urandom_range(0, 5) == 0);
      flush_e_i      = ($urandom_range(0, 5) == 0);
      instr_f_i      = $urandom;
      rd1_d_i        = $urandom;
      rd2_d_i        = $urandom;
      imm_ext_d_i    = $urandom;
      ctrl_d_i       = 16'($urandom);
      alu_result_m_i = $urandom;
      result_w_i     = $urandom;
      forward_a_e_i  = 2'($urandom_range(0, 3));
      forward_b_e_i  = 2'($urandom_range(0, 3));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
